// File: rtl/kp_filter3x3_top.sv
// kp_filter3x3_top
// 3x3 neighbourhood filter for packed multi-channel pixels (default RGB565).
// The filter mode is chosen per frame: passthrough, Gaussian (1 2 1 kernel),
// max (dilate) or min (erode). Line buffers, window registers and the output
// FIFO are all internal. Input reads are only issued when the output FIFO is
// guaranteed to have room for every pixel already in flight, so no data is
// ever dropped.
//
// Ports:
//   i_clk          clock
//   i_rstn         synchronous active-low reset
//   i_flush        synchronous clear of everything except the mode latch
//   i_mode         0 passthrough, 1 Gaussian, 2 max, 3 min (latched at pixel (0,0))
//   i_data         input FIFO read data, valid the cycle after o_rd
//   i_almostempty  input FIFO almost-empty
//   o_rd           input FIFO read strobe (registered)
//   i_obuf_rd      output FIFO read
//   o_obuf_data    output FIFO read data, valid the cycle after i_obuf_rd
//   o_obuf_fill    output FIFO occupancy
//   o_obuf_full    output FIFO full
//   o_obuf_empty   output FIFO empty
//   o_frame_done   one-cycle pulse with the write of the last pixel of a frame
//   o_error        sticky overflow/underflow flag
module kp_filter3x3_top #(
    parameter int                  LINE_LENGTH    = 480,
    parameter int                  LINE_COUNT     = 480,
    parameter int                  NUM_CH         = 3,
    parameter logic [8*NUM_CH-1:0] CH_WIDTHS      = 24'h050605,
    parameter int                  DATA_WIDTH     = 16,
    parameter int                  OBUF_PTR_WIDTH = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic                      i_flush,
    input  logic [1:0]                i_mode,
    input  logic [DATA_WIDTH-1:0]     i_data,
    input  logic                      i_almostempty,
    output logic                      o_rd,
    input  logic                      i_obuf_rd,
    output logic [DATA_WIDTH-1:0]     o_obuf_data,
    output logic [OBUF_PTR_WIDTH:0]   o_obuf_fill,
    output logic                      o_obuf_full,
    output logic                      o_obuf_empty,
    output logic                      o_frame_done,
    output logic                      o_error
);

    localparam int DEPTH = 1 << OBUF_PTR_WIDTH;
    localparam int COL_W = $clog2(LINE_LENGTH);
    localparam int ROW_W = $clog2(LINE_COUNT);
    localparam int SUM_W = OBUF_PTR_WIDTH + 2;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LENGTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(LINE_COUNT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_GAUSS = 2'd1,
        MODE_MAX   = 2'd2,
        MODE_MIN   = 2'd3
    } mode_t;

    // Width of channel field i (field 0 is the LSB channel).
    function automatic int ch_width(input int i);
        return int'(CH_WIDTHS[8*i +: 8]);
    endfunction

    // Bit offset of channel i inside the packed pixel.
    function automatic int ch_offset(input int i);
        int off;
        off = 0;
        for (int j = 0; j < i; j++) begin
            off += ch_width(j);
        end
        return off;
    endfunction

    logic                   clear;
    logic                   din_valid;
    logic [COL_W-1:0]       col;
    logic [ROW_W-1:0]       row;
    logic                   at_origin;
    mode_t                  frame_mode;
    mode_t                  cur_mode;

    logic [DATA_WIDTH-1:0]  lb1 [LINE_LENGTH];
    logic [DATA_WIDTH-1:0]  lb2 [LINE_LENGTH];
    logic [DATA_WIDTH-1:0]  new_col [3];
    logic [DATA_WIDTH-1:0]  win  [3][3];
    logic [DATA_WIDTH-1:0]  vwin [3][3];

    logic                   s1_valid;
    logic                   s1_last;
    mode_t                  s1_mode;
    logic [DATA_WIDTH-1:0]  s1_pix;

    logic [DATA_WIDTH-1:0]  gauss_pix;
    logic [DATA_WIDTH-1:0]  max_pix;
    logic [DATA_WIDTH-1:0]  min_pix;
    logic [DATA_WIDTH-1:0]  wr_data;

    logic [1:0]             inflight;
    logic                   credit_ok;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [OBUF_PTR_WIDTH-1:0] wptr;
    logic [OBUF_PTR_WIDTH-1:0] rptr;
    logic [OBUF_PTR_WIDTH:0]   fill;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   do_wr;
    logic                   do_rd;

    assign clear     = !i_rstn || i_flush;
    assign at_origin = (col == '0) && (row == '0);

    // The mode of pixel (0,0) is taken straight from the port so that the
    // very first pixel of a frame already uses the new mode.
    assign cur_mode = at_origin ? mode_t'(i_mode) : frame_mode;

    // Read issue. Every pixel in the pipeline (read strobe, input data and
    // stage 1) is counted as a future write whether or not it will actually
    // produce an output, so the FIFO can never overflow.
    assign inflight  = {1'b0, o_rd} + {1'b0, din_valid} + {1'b0, s1_valid};
    assign credit_ok = (SUM_W'(fill) + SUM_W'(inflight)) <= SUM_W'(DEPTH - 1);

    always_ff @(posedge i_clk) begin
        if (clear) begin
            o_rd      <= 1'b0;
            din_valid <= 1'b0;
        end else begin
            o_rd      <= !i_almostempty && credit_ok;
            din_valid <= o_rd;
        end
    end

    always_ff @(posedge i_clk) begin
        if (clear) begin
            col <= '0;
            row <= '0;
        end else if (din_valid) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Flush deliberately leaves the mode latch alone; only reset clears it.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            frame_mode <= MODE_PASS;
        end else if (din_valid && at_origin && !i_flush) begin
            frame_mode <= mode_t'(i_mode);
        end
    end

    // Line buffers hold rows r-1 (lb1) and r-2 (lb2), indexed by column.
    always_ff @(posedge i_clk) begin
        if (clear) begin
            for (int i = 0; i < LINE_LENGTH; i++) begin
                lb1[i] <= '0;
                lb2[i] <= '0;
            end
        end else if (din_valid) begin
            lb1[col] <= i_data;
            lb2[col] <= lb1[col];
        end
    end

    // The window used by stage 1 is the registered window shifted by one
    // column with the incoming column appended, so the stage-1 maths runs in
    // the same cycle the pixel arrives. Row index 0 is the oldest line.
    always_comb begin
        new_col[0] = lb2[col];
        new_col[1] = lb1[col];
        new_col[2] = i_data;
        for (int k = 0; k < 3; k++) begin
            vwin[k][0] = win[k][1];
            vwin[k][1] = win[k][2];
            vwin[k][2] = new_col[k];
        end
    end

    always_ff @(posedge i_clk) begin
        if (clear) begin
            for (int k = 0; k < 3; k++) begin
                for (int t = 0; t < 3; t++) begin
                    win[k][t] <= '0;
                end
            end
        end else if (din_valid) begin
            for (int k = 0; k < 3; k++) begin
                for (int t = 0; t < 3; t++) begin
                    win[k][t] <= vwin[k][t];
                end
            end
        end
    end

    // Stage 1 control. The window is complete once two full columns and two
    // full rows precede the current pixel; passthrough writes every pixel.
    always_ff @(posedge i_clk) begin
        if (clear) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_mode  <= MODE_PASS;
            s1_pix   <= '0;
        end else begin
            s1_valid <= din_valid &&
                        ((cur_mode == MODE_PASS) || ((row >= ROW_TWO) && (col >= COL_TWO)));
            s1_last  <= din_valid && (row == ROW_LAST) && (col == COL_LAST);
            if (din_valid) begin
                s1_mode <= cur_mode;
                s1_pix  <= i_data;
            end
        end
    end

    // Per-channel datapath: stage 1 reduces each window row, stage 2
    // combines the three rows.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        localparam int W   = ch_width(ch);
        localparam int OFF = ch_offset(ch);

        logic [W-1:0] tap     [3][3];
        logic [W+1:0] row_sum [3];
        logic [W-1:0] max01   [3];
        logic [W-1:0] min01   [3];
        logic [W-1:0] row_max [3];
        logic [W-1:0] row_min [3];

        logic [W+1:0] s1_sum  [3];
        logic [W-1:0] s1_max  [3];
        logic [W-1:0] s1_min  [3];

        logic [W+3:0] g_total;
        logic [W-1:0] m_max01;
        logic [W-1:0] m_min01;
        logic [W-1:0] m_max;
        logic [W-1:0] m_min;

        always_comb begin
            for (int k = 0; k < 3; k++) begin
                for (int t = 0; t < 3; t++) begin
                    tap[k][t] = vwin[k][t][OFF +: W];
                end
                row_sum[k] = (W+2)'(tap[k][0]) + ((W+2)'(tap[k][1]) << 1) + (W+2)'(tap[k][2]);
                max01[k]   = (tap[k][0] > tap[k][1]) ? tap[k][0] : tap[k][1];
                min01[k]   = (tap[k][0] < tap[k][1]) ? tap[k][0] : tap[k][1];
                row_max[k] = (max01[k] > tap[k][2]) ? max01[k] : tap[k][2];
                row_min[k] = (min01[k] < tap[k][2]) ? min01[k] : tap[k][2];
            end
        end

        always_ff @(posedge i_clk) begin
            if (clear) begin
                for (int k = 0; k < 3; k++) begin
                    s1_sum[k] <= '0;
                    s1_max[k] <= '0;
                    s1_min[k] <= '0;
                end
            end else if (din_valid) begin
                for (int k = 0; k < 3; k++) begin
                    s1_sum[k] <= row_sum[k];
                    s1_max[k] <= row_max[k];
                    s1_min[k] <= row_min[k];
                end
            end
        end

        // Kernel weights total 16, so dropping the low 4 bits normalises
        // (truncating) and the result always fits back into W bits.
        always_comb begin
            g_total = (W+4)'(s1_sum[0]) + ((W+4)'(s1_sum[1]) << 1) + (W+4)'(s1_sum[2]);
            m_max01 = (s1_max[0] > s1_max[1]) ? s1_max[0] : s1_max[1];
            m_min01 = (s1_min[0] < s1_min[1]) ? s1_min[0] : s1_min[1];
            m_max   = (m_max01 > s1_max[2]) ? m_max01 : s1_max[2];
            m_min   = (m_min01 < s1_min[2]) ? m_min01 : s1_min[2];
        end

        assign gauss_pix[OFF +: W] = g_total[W+3:4];
        assign max_pix[OFF +: W]   = m_max;
        assign min_pix[OFF +: W]   = m_min;
    end

    always_comb begin
        wr_data = s1_pix;
        case (s1_mode)
            MODE_PASS:  wr_data = s1_pix;
            MODE_GAUSS: wr_data = gauss_pix;
            MODE_MAX:   wr_data = max_pix;
            MODE_MIN:   wr_data = min_pix;
            default:    wr_data = s1_pix;
        endcase
    end

    // Output FIFO. A write into a full FIFO is accepted only when a read
    // frees a slot in the same cycle.
    assign fifo_full  = (fill == (OBUF_PTR_WIDTH+1)'(DEPTH));
    assign fifo_empty = (fill == '0);
    assign do_rd      = i_obuf_rd && !fifo_empty;
    assign do_wr      = s1_valid && (!fifo_full || do_rd);

    always_ff @(posedge i_clk) begin
        if (do_wr) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (clear) begin
            wptr <= '0;
            rptr <= '0;
            fill <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + 1'b1;
            end
            if (do_rd) begin
                rptr <= rptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                fill <= fill + 1'b1;
            end else if (!do_wr && do_rd) begin
                fill <= fill - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (clear) begin
            o_obuf_data  <= '0;
            o_frame_done <= 1'b0;
            o_error      <= 1'b0;
        end else begin
            if (do_rd) begin
                o_obuf_data <= mem[rptr];
            end
            o_frame_done <= do_wr && s1_last;
            if ((s1_valid && !do_wr) || (i_obuf_rd && fifo_empty)) begin
                o_error <= 1'b1;
            end
        end
    end

    assign o_obuf_fill  = fill;
    assign o_obuf_full  = fifo_full;
    assign o_obuf_empty = fifo_empty;

endmodule

// File: tb/tb_kp_filter3x3_top.sv
// tb_kp_filter3x3_top
// Self-checking bench for kp_filter3x3_top on a 4x4 frame with a 4-deep
// output FIFO. The bench plays the role of the input FIFO and of the
// downstream reader. Expected outputs come either from hand-computed lists
// or from an image-level model of the 3x3 filters.
module tb_kp_filter3x3_top;

    localparam int LL    = 4;
    localparam int LC    = 4;
    localparam int PW    = 2;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << PW;
    localparam int NPIX  = LL * LC;

    typedef logic [DW-1:0] img_t [NPIX];
    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    mode;
    } src_t;

    logic          i_clk = 1'b0;
    logic          i_rstn = 1'b0;
    logic          i_flush = 1'b0;
    logic [1:0]    i_mode = 2'd0;
    logic [DW-1:0] i_data = '0;
    logic          i_almostempty = 1'b1;
    logic          o_rd;
    logic          i_obuf_rd = 1'b0;
    logic [DW-1:0] o_obuf_data;
    logic [PW:0]   o_obuf_fill;
    logic          o_obuf_full;
    logic          o_obuf_empty;
    logic          o_frame_done;
    logic          o_error;

    src_t          src_q[$];
    logic [DW-1:0] exp_q[$];
    src_t          cur_s;

    int  checks     = 0;
    int  failures   = 0;
    int  done_cnt   = 0;
    int  done_exp   = 0;
    bit  checking   = 1'b0;
    bit  block_reads = 1'b1;
    bit  stall_rand = 1'b0;
    int  rd_mode    = 0;
    bit  rd_prev    = 1'b0;
    bit  rd_pend    = 1'b0;

    always #5 i_clk = ~i_clk;

    kp_filter3x3_top #(
        .LINE_LENGTH    (LL),
        .LINE_COUNT     (LC),
        .NUM_CH         (3),
        .CH_WIDTHS      (24'h050605),
        .DATA_WIDTH     (DW),
        .OBUF_PTR_WIDTH (PW)
    ) dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_flush       (i_flush),
        .i_mode        (i_mode),
        .i_data        (i_data),
        .i_almostempty (i_almostempty),
        .o_rd          (o_rd),
        .i_obuf_rd     (i_obuf_rd),
        .o_obuf_data   (o_obuf_data),
        .o_obuf_fill   (o_obuf_fill),
        .o_obuf_full   (o_obuf_full),
        .o_obuf_empty  (o_obuf_empty),
        .o_frame_done  (o_frame_done),
        .o_error       (o_error)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Value v replicated into the R, G and B fields of an RGB565 pixel.
    function automatic logic [DW-1:0] pack_rep(input int v);
        return DW'((v << 11) | (v << 5) | v);
    endfunction

    // Image-level reference for the filtered pixel centred on (r,c).
    function automatic logic [DW-1:0] model_pix(input img_t img, input int mode, input int r, input int c);
        int sh [3];
        int wd [3];
        int mask, v, wt, acc, mx, mn, o;
        logic [DW-1:0] res;
        sh = '{11, 5, 0};
        wd = '{5, 6, 5};
        res = '0;
        for (int ch = 0; ch < 3; ch++) begin
            mask = (1 << wd[ch]) - 1;
            acc = 0;
            mx = 0;
            mn = mask;
            for (int dr = -1; dr <= 1; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    v   = (int'(img[(r + dr) * LL + c + dc]) >> sh[ch]) & mask;
                    wt  = ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1);
                    acc += wt * v;
                    if (v > mx) mx = v;
                    if (v < mn) mn = v;
                end
            end
            case (mode)
                1:       o = acc / 16;
                2:       o = mx;
                3:       o = mn;
                default: o = 0;
            endcase
            res = res | DW'(o << sh[ch]);
        end
        return res;
    endfunction

    task automatic expectModel(input img_t img, input int mode);
        if (mode == 0) begin
            for (int i = 0; i < NPIX; i++) exp_q.push_back(img[i]);
        end else begin
            for (int r = 1; r < LC - 1; r++) begin
                for (int c = 1; c < LL - 1; c++) begin
                    exp_q.push_back(model_pix(img, mode, r, c));
                end
            end
        end
    endtask

    task automatic expectList(input int a, input int b, input int c, input int d);
        exp_q.push_back(pack_rep(a));
        exp_q.push_back(pack_rep(b));
        exp_q.push_back(pack_rep(c));
        exp_q.push_back(pack_rep(d));
    endtask

    // Queue npix pixels of img; from pixel index 7 on, late_mode (if >= 0)
    // is presented on i_mode instead of mode.
    task automatic applyStimulus(input img_t img, input int mode, input int late_mode, input int npix);
        src_t s;
        for (int i = 0; i < npix; i++) begin
            s.data = img[i];
            s.mode = (late_mode >= 0 && i >= 7) ? 2'(late_mode) : 2'(mode);
            src_q.push_back(s);
        end
    endtask

    task automatic waitDrain(input string name);
        int quiet;
        quiet = 0;
        for (int i = 0; i < 3000 && quiet < 8; i++) begin
            @(negedge i_clk);
            if (src_q.size() == 0 && exp_q.size() == 0 && o_obuf_fill == 0 && !o_rd && !rd_pend)
                quiet++;
            else
                quiet = 0;
        end
        checkOutput({name, "_drained"}, (quiet >= 8), 1);
        checkOutput({name, "_frame_done_count"}, done_cnt, done_exp);
    endtask

    task automatic doFlush(input string name);
        @(posedge i_clk);
        #2 i_flush = 1'b1;
        @(posedge i_clk);
        #2 i_flush = 1'b0;
        src_q.delete();
        exp_q.delete();
        @(negedge i_clk);
        checkOutput({name, "_fill"}, o_obuf_fill, 0);
        checkOutput({name, "_empty"}, o_obuf_empty, 1);
        checkOutput({name, "_rd"}, o_rd, 0);
        checkOutput({name, "_data"}, o_obuf_data, 0);
    endtask

    // Input FIFO and downstream reader. Data for a read strobe seen in one
    // cycle is presented in the following cycle together with its mode.
    always @(posedge i_clk) begin
        #1;
        if (rd_prev) begin
            if (src_q.size() == 0) begin
                checkOutput("input_underflow", 1, 0);
            end else begin
                cur_s  = src_q.pop_front();
                i_data = cur_s.data;
                i_mode = cur_s.mode;
            end
        end
        rd_prev = o_rd;
        i_almostempty = block_reads || (stall_rand && ($urandom_range(0, 2) == 0)) ||
                        (src_q.size() <= (o_rd ? 1 : 0));
        case (rd_mode)
            1:       i_obuf_rd = !o_obuf_empty;
            2:       i_obuf_rd = !o_obuf_empty && ($urandom_range(0, 1) == 1);
            default: i_obuf_rd = 1'b0;
        endcase
    end

    // Compare process: output data against the expected queue plus per-cycle
    // flag consistency.
    always @(negedge i_clk) begin
        if (checking) begin
            if (rd_pend) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_output actual=%0h required=none", o_obuf_data);
                end else begin
                    checkOutput("obuf_data", o_obuf_data, exp_q.pop_front());
                end
            end
            rd_pend = i_obuf_rd;
            checkOutput("error_flag", o_error, 0);
            checkOutput("fill_within_depth", (o_obuf_fill <= DEPTH), 1);
            checkOutput("empty_flag", o_obuf_empty, (o_obuf_fill == 0));
            checkOutput("full_flag", o_obuf_full, (o_obuf_fill == DEPTH));
            if (o_frame_done) done_cnt++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        img_t img;
        img_t rimg;
        int   seen;
        int   rmode;

        for (int i = 0; i < NPIX; i++) img[i] = pack_rep(i);

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checkOutput("reset_rd", o_rd, 0);
        checkOutput("reset_data", o_obuf_data, 0);
        checkOutput("reset_fill", o_obuf_fill, 0);
        checkOutput("reset_empty", o_obuf_empty, 1);
        checkOutput("reset_full", o_obuf_full, 0);
        checkOutput("reset_frame_done", o_frame_done, 0);
        checkOutput("reset_error", o_error, 0);
        @(posedge i_clk);
        #2 i_rstn = 1'b1;
        checking = 1'b1;

        checkOutput("model_gauss_11", model_pix(img, 1, 1, 1), pack_rep(5));
        checkOutput("model_gauss_22", model_pix(img, 1, 2, 2), pack_rep(10));
        checkOutput("model_max_22", model_pix(img, 2, 2, 2), pack_rep(15));
        checkOutput("model_min_12", model_pix(img, 3, 1, 2), pack_rep(1));

        $display("[TB] Gaussian frame");
        block_reads = 1'b0;
        rd_mode = 1;
        applyStimulus(img, 1, -1, NPIX);
        expectList(5, 6, 9, 10);
        done_exp++;
        waitDrain("gauss");

        $display("[TB] max and min frames");
        applyStimulus(img, 2, -1, NPIX);
        expectList(10, 11, 14, 15);
        applyStimulus(img, 3, -1, NPIX);
        expectList(0, 1, 4, 5);
        done_exp += 2;
        waitDrain("maxmin");

        $display("[TB] passthrough frame and latency");
        rd_mode = 0;
        applyStimulus(img, 0, -1, NPIX);
        for (int i = 0; i < NPIX; i++) exp_q.push_back(img[i]);
        done_exp++;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge i_clk);
            if (o_rd) seen = 1;
        end
        checkOutput("pass_first_read_seen", seen, 1);
        repeat (2) @(negedge i_clk);
        checkOutput("pass_fill_before_write", o_obuf_fill, 0);
        @(negedge i_clk);
        checkOutput("pass_fill_after_write", o_obuf_fill, 1);
        rd_mode = 1;
        waitDrain("pass");

        $display("[TB] backpressure");
        rd_mode = 0;
        applyStimulus(img, 1, -1, NPIX);
        expectList(5, 6, 9, 10);
        done_exp++;
        repeat (40) @(negedge i_clk);
        checkOutput("bp_fill_full", o_obuf_fill, DEPTH);
        rd_mode = 1;
        waitDrain("backpressure");

        $display("[TB] mode change mid-frame");
        applyStimulus(img, 1, 2, NPIX);
        expectList(5, 6, 9, 10);
        applyStimulus(img, 2, -1, NPIX);
        expectList(10, 11, 14, 15);
        done_exp += 2;
        waitDrain("mode_latch");

        $display("[TB] flush");
        rd_mode = 0;
        applyStimulus(img, 0, -1, 7);
        repeat (30) @(negedge i_clk);
        checkOutput("pass_partial_fill", o_obuf_fill, DEPTH);
        block_reads = 1'b1;
        repeat (4) @(negedge i_clk);
        doFlush("flush_pass");
        block_reads = 1'b0;
        rd_mode = 1;
        applyStimulus(img, 1, -1, 7);
        repeat (30) @(negedge i_clk);
        checkOutput("gauss_partial_fill", o_obuf_fill, 0);
        block_reads = 1'b1;
        repeat (3) @(negedge i_clk);
        doFlush("flush_gauss");
        block_reads = 1'b0;
        applyStimulus(img, 1, -1, NPIX);
        expectList(5, 6, 9, 10);
        done_exp++;
        waitDrain("after_flush");

        $display("[TB] random frames");
        stall_rand = 1'b1;
        rd_mode = 2;
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < NPIX; i++) rimg[i] = DW'($urandom);
            rmode = int'($urandom_range(0, 3));
            applyStimulus(rimg, rmode, -1, NPIX);
            expectModel(rimg, rmode);
            done_exp++;
            if (f % 2 == 1) waitDrain("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
